// File: rtl/smaesh_scheduler.sv
// Sequencer in front of a masked AES core: arbitrates host seed, key and data
// streams, tracks in-flight blocks and forces a PRNG reseed every RESEED_PERIOD blocks.
//
// state | meaning
// IDLE  | data may flow; seed/key requests are arbitrated (seed > key > data)
// DRAIN | seed/key pending, waiting for in-flight blocks to leave the core
// SEED  | seed stream passed through to the core until one handshake
// KEY   | key words passed through until the latched word count is reached
module smaesh_scheduler #(
  parameter int RESEED_PERIOD = 1024,
  parameter int MAX_INFLIGHT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        h_seed_valid,
  output logic        h_seed_ready,
  input  logic [79:0] h_seed_data,
  input  logic        h_key_valid,
  output logic        h_key_ready,
  input  logic [31:0] h_key_data,
  input  logic [1:0]  h_key_size_cfg,
  input  logic        h_key_inverse,
  input  logic        h_data_valid,
  output logic        h_data_ready,
  output logic        c_seed_valid,
  input  logic        c_seed_ready,
  output logic [79:0] c_seed_data,
  output logic        c_key_valid,
  input  logic        c_key_ready,
  output logic [31:0] c_key_data,
  output logic [1:0]  c_key_size_cfg,
  output logic        c_key_inverse,
  output logic        c_data_valid,
  input  logic        c_data_ready,
  input  logic        c_out_valid,
  input  logic        c_out_ready,
  output logic        reseed_req,
  output logic        busy,
  output logic        err,
  output logic [1:0]  inflight
);

  localparam int CW = (RESEED_PERIOD < 2) ? 1 : $clog2(RESEED_PERIOD + 1);
  localparam logic [CW-1:0] PERIOD = CW'(RESEED_PERIOD);
  localparam logic [1:0] MAX_IF = 2'(MAX_INFLIGHT);
  localparam logic RESEED_EN = (RESEED_PERIOD != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_SEED  = 2'd2,
    S_KEY   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [CW-1:0] blk_cnt, blk_cnt_next;
  logic [1:0]    inflight_next;
  logic [2:0]    word_cnt;
  logic [2:0]    last_idx;
  logic [1:0]    cfg_q;
  logic          inv_q;
  logic          seeded;
  logic          keyed;

  logic seed_hs, key_hs, key_last, data_open, data_hs, out_hs, out_ok;
  logic enter_key, bad_cfg;
  logic [1:0] cfg_eff;

  // Data is only offered to the core when nothing else is pending or required.
  assign data_open = (state == S_IDLE) && seeded && keyed && !h_seed_valid &&
                     !h_key_valid && (inflight < MAX_IF) && !reseed_req;

  assign seed_hs   = (state == S_SEED) && h_seed_valid && c_seed_ready;
  assign key_hs    = (state == S_KEY) && h_key_valid && c_key_ready;
  assign key_last  = key_hs && (word_cnt == last_idx);
  assign data_hs   = h_data_valid && h_data_ready;
  assign out_hs    = c_out_valid && c_out_ready;
  assign out_ok    = out_hs && (inflight != 2'd0);
  assign enter_key = (state_next == S_KEY) && (state != S_KEY);
  assign bad_cfg   = (h_key_size_cfg == 2'd3);
  assign cfg_eff   = bad_cfg ? 2'd0 : h_key_size_cfg;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (h_seed_valid)
          state_next = (inflight == 2'd0) ? S_SEED : S_DRAIN;
        else if (h_key_valid)
          state_next = (inflight == 2'd0) ? S_KEY : S_DRAIN;
      end
      S_DRAIN: begin
        if (inflight == 2'd0) begin
          if (h_seed_valid)     state_next = S_SEED;
          else if (h_key_valid) state_next = S_KEY;
          else                  state_next = S_IDLE;
        end
      end
      S_SEED: if (seed_hs) state_next = S_IDLE;
      S_KEY:  if (key_last) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    h_seed_ready   = 1'b0;
    c_seed_valid   = 1'b0;
    h_key_ready    = 1'b0;
    c_key_valid    = 1'b0;
    c_seed_data    = h_seed_data;
    c_key_data     = h_key_data;
    c_key_size_cfg = cfg_q;
    c_key_inverse  = inv_q;
    h_data_ready   = c_data_ready && data_open;
    c_data_valid   = h_data_valid && data_open;
    busy           = (state != S_IDLE) || (inflight != 2'd0);
    if (state == S_SEED) begin
      c_seed_valid = h_seed_valid;
      h_seed_ready = c_seed_ready;
    end
    if (state == S_KEY) begin
      c_key_valid = h_key_valid;
      h_key_ready = c_key_ready;
    end
  end

  always_comb begin
    blk_cnt_next = blk_cnt;
    if (seed_hs)
      blk_cnt_next = '0;
    else if (data_hs && (blk_cnt != PERIOD))
      blk_cnt_next = blk_cnt + 1'b1;
  end

  always_comb begin
    inflight_next = inflight;
    if (data_hs && !out_ok)
      inflight_next = inflight + 2'd1;
    else if (!data_hs && out_ok)
      inflight_next = inflight - 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      blk_cnt    <= '0;
      inflight   <= 2'd0;
      reseed_req <= 1'b0;
      seeded     <= 1'b0;
      keyed      <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      blk_cnt    <= blk_cnt_next;
      inflight   <= inflight_next;
      // Tracks blk_cnt_next so the request rises with the final block and drops with the seed.
      reseed_req <= RESEED_EN && (blk_cnt_next == PERIOD);
      if (seed_hs)  seeded <= 1'b1;
      if (key_last) keyed  <= 1'b1;
      if ((out_hs && (inflight == 2'd0)) || (enter_key && bad_cfg))
        err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_q    <= 2'd0;
      inv_q    <= 1'b0;
      last_idx <= 3'd3;
      word_cnt <= 3'd0;
    end else if (enter_key) begin
      cfg_q    <= cfg_eff;
      inv_q    <= h_key_inverse;
      word_cnt <= 3'd0;
      case (cfg_eff)
        2'd1:    last_idx <= 3'd5;
        2'd2:    last_idx <= 3'd7;
        default: last_idx <= 3'd3;
      endcase
    end else if (key_hs) begin
      word_cnt <= word_cnt + 3'd1;
    end
  end

  a_inflight_bound: assert property (@(posedge clk) disable iff (!rst) inflight <= MAX_IF);

endmodule

// File: tb/tb_smaesh_scheduler.sv
// Directed bench for smaesh_scheduler: a gating-vector table in IDLE plus
// hand-written bring-up, reseed, drain, arbitration and mid-key reset sequences.
module tb_smaesh_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        h_seed_valid, h_seed_ready;
  logic [79:0] h_seed_data;
  logic        h_key_valid, h_key_ready;
  logic [31:0] h_key_data;
  logic [1:0]  h_key_size_cfg;
  logic        h_key_inverse;
  logic        h_data_valid, h_data_ready;
  logic        c_seed_valid, c_seed_ready;
  logic [79:0] c_seed_data;
  logic        c_key_valid, c_key_ready;
  logic [31:0] c_key_data;
  logic [1:0]  c_key_size_cfg;
  logic        c_key_inverse;
  logic        c_data_valid, c_data_ready;
  logic        c_out_valid, c_out_ready;
  logic        reseed_req, busy, err;
  logic [1:0]  inflight;

  int total = 0;
  int bad   = 0;

  smaesh_scheduler #(.RESEED_PERIOD(3), .MAX_INFLIGHT(2)) dut (
    .clk(clk), .rst(rst),
    .h_seed_valid(h_seed_valid), .h_seed_ready(h_seed_ready), .h_seed_data(h_seed_data),
    .h_key_valid(h_key_valid), .h_key_ready(h_key_ready), .h_key_data(h_key_data),
    .h_key_size_cfg(h_key_size_cfg), .h_key_inverse(h_key_inverse),
    .h_data_valid(h_data_valid), .h_data_ready(h_data_ready),
    .c_seed_valid(c_seed_valid), .c_seed_ready(c_seed_ready), .c_seed_data(c_seed_data),
    .c_key_valid(c_key_valid), .c_key_ready(c_key_ready), .c_key_data(c_key_data),
    .c_key_size_cfg(c_key_size_cfg), .c_key_inverse(c_key_inverse),
    .c_data_valid(c_data_valid), .c_data_ready(c_data_ready),
    .c_out_valid(c_out_valid), .c_out_ready(c_out_ready),
    .reseed_req(reseed_req), .busy(busy), .err(err), .inflight(inflight)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic hdv, cdr, hsv, hkv;
    logic exp_hdr, exp_cdv;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assumes IDLE with inflight==0 and no other request pending.
  task automatic do_seed(input logic [79:0] d);
    h_seed_valid = 1'b1;
    h_seed_data  = d;
    c_seed_ready = 1'b0;
    tick();
    chk("seed_cvalid", c_seed_valid, 1);
    chk("seed_cdata", c_seed_data, d);
    chk("seed_hready_stall", h_seed_ready, 0);
    c_seed_ready = 1'b1;
    #1;
    chk("seed_hready", h_seed_ready, 1);
    tick();
    h_seed_valid = 1'b0;
    c_seed_ready = 1'b0;
    chk("seed_back_idle", busy, 0);
  endtask

  // Called with the DUT already in KEY; host keeps offering words until the DUT leaves KEY.
  task automatic run_key(input int exp_words, input logic [1:0] exp_cfg, input logic exp_inv);
    int  n = 0;
    bit  done = 0;
    logic hs;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      c_key_ready    = ((cyc % 3) != 1);
      h_key_data     = 32'hA000_0000 + 32'(n);
      h_key_size_cfg = 2'(cyc);
      h_key_inverse  = ~exp_inv;
      #1;
      chk("key_cvalid", c_key_valid, 1);
      chk("key_cdata", c_key_data, 32'hA000_0000 + 32'(n));
      chk("key_cfg_latched", c_key_size_cfg, exp_cfg);
      chk("key_inv_latched", c_key_inverse, exp_inv);
      hs = h_key_ready;
      tick();
      if (hs) n++;
      if (!busy) done = 1;
    end
    h_key_valid = 1'b0;
    c_key_ready = 1'b0;
    chk("key_finished", done, 1);
    chk("key_word_count", n, exp_words);
  endtask

  initial begin
    tbl[0] = '{hdv:1, cdr:1, hsv:0, hkv:0, exp_hdr:1, exp_cdv:1};
    tbl[1] = '{hdv:1, cdr:0, hsv:0, hkv:0, exp_hdr:0, exp_cdv:1};
    tbl[2] = '{hdv:0, cdr:1, hsv:0, hkv:0, exp_hdr:1, exp_cdv:0};
    tbl[3] = '{hdv:1, cdr:1, hsv:1, hkv:0, exp_hdr:0, exp_cdv:0};
    tbl[4] = '{hdv:1, cdr:1, hsv:0, hkv:1, exp_hdr:0, exp_cdv:0};
    tbl[5] = '{hdv:0, cdr:0, hsv:1, hkv:1, exp_hdr:0, exp_cdv:0};

    rst = 1'b0;
    h_seed_valid = 0; h_seed_data = '0;
    h_key_valid = 0; h_key_data = '0; h_key_size_cfg = 0; h_key_inverse = 0;
    h_data_valid = 1; c_data_ready = 1;
    c_seed_ready = 1; c_key_ready = 1;
    c_out_valid = 0; c_out_ready = 0;

    // Reset state
    tick(); tick();
    chk("rst_h_seed_ready", h_seed_ready, 0);
    chk("rst_h_key_ready", h_key_ready, 0);
    chk("rst_h_data_ready", h_data_ready, 0);
    chk("rst_c_seed_valid", c_seed_valid, 0);
    chk("rst_c_key_valid", c_key_valid, 0);
    chk("rst_c_data_valid", c_data_valid, 0);
    chk("rst_reseed_req", reseed_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_key_cfg", c_key_size_cfg, 0);
    rst = 1'b1;
    c_seed_ready = 0; c_key_ready = 0;

    // Data before any seed/key is never accepted
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("nodata_h_data_ready", h_data_ready, 0);
      chk("nodata_c_data_valid", c_data_valid, 0);
      chk("nodata_err", err, 0);
    end
    h_data_valid = 0; c_data_ready = 0;

    // Bring-up: seed, then 8-word key
    do_seed(80'h1234_5678_9ABC_DEF0_1111);
    h_key_valid = 1; h_key_size_cfg = 2; h_key_inverse = 1;
    tick();
    chk("bringup_key_busy", busy, 1);
    run_key(8, 2'd2, 1'b1);
    chk("bringup_idle", busy, 0);
    chk("bringup_err", err, 0);

    // IDLE gating vectors; inputs removed before each edge so nothing is accepted
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      h_data_valid = tbl[i].hdv; c_data_ready = tbl[i].cdr;
      h_seed_valid = tbl[i].hsv; h_key_valid  = tbl[i].hkv;
      c_seed_ready = 1; c_key_ready = 1;
      #1;
      chk($sformatf("tbl%0d_h_data_ready", i), h_data_ready, tbl[i].exp_hdr);
      chk($sformatf("tbl%0d_c_data_valid", i), c_data_valid, tbl[i].exp_cdv);
      chk($sformatf("tbl%0d_h_seed_ready", i), h_seed_ready, 0);
      chk($sformatf("tbl%0d_h_key_ready", i), h_key_ready, 0);
      chk($sformatf("tbl%0d_c_seed_valid", i), c_seed_valid, 0);
      chk($sformatf("tbl%0d_c_key_valid", i), c_key_valid, 0);
      #1;
      h_data_valid = 0; c_data_ready = 0; h_seed_valid = 0; h_key_valid = 0;
      c_seed_ready = 0; c_key_ready = 0;
    end

    // Forced reseed after 3 blocks; simultaneous accept+output keeps inflight
    h_data_valid = 1; c_data_ready = 1;
    tick();
    chk("rs_inflight1", inflight, 1);
    chk("rs_req_early", reseed_req, 0);
    c_out_valid = 1; c_out_ready = 1;
    tick();
    chk("rs_inflight_same2", inflight, 1);
    tick();
    chk("rs_inflight_same3", inflight, 1);
    chk("rs_req_set", reseed_req, 1);
    chk("rs_blocked_ready", h_data_ready, 0);
    chk("rs_blocked_valid", c_data_valid, 0);
    h_data_valid = 0;
    tick();
    chk("rs_drained", inflight, 0);
    c_out_valid = 0; c_out_ready = 0;
    tick();
    chk("rs_req_held", reseed_req, 1);
    chk("rs_err", err, 0);
    do_seed(80'hCAFE_0000_0000_0000_0003);
    chk("rs_req_cleared", reseed_req, 0);
    h_data_valid = 1; c_data_ready = 1;
    #1;
    chk("rs_data_reopen", h_data_ready, 1);
    tick();
    tick();
    chk("max_inflight", inflight, 2);
    chk("max_inflight_block", h_data_ready, 0);

    // Drain: key request with 2 blocks in flight
    h_key_valid = 1; h_key_size_cfg = 0; h_key_inverse = 1; c_key_ready = 1;
    tick();
    chk("drain_busy", busy, 1);
    chk("drain_key_ready", h_key_ready, 0);
    chk("drain_no_data", h_data_ready, 0);
    chk("drain_inflight", inflight, 2);
    c_out_valid = 1; c_out_ready = 1;
    tick();
    chk("drain_inflight1", inflight, 1);
    chk("drain_key_ready1", h_key_ready, 0);
    tick();
    chk("drain_inflight0", inflight, 0);
    chk("drain_still_drain", h_key_ready, 0);
    chk("drain_still_busy", busy, 1);
    c_out_valid = 0; c_out_ready = 0; h_data_valid = 0;
    tick();
    chk("drain_key_entered", h_key_ready, 1);
    run_key(4, 2'd0, 1'b1);
    chk("drain_err", err, 0);

    // Spurious output handshake
    c_out_valid = 1; c_out_ready = 1;
    tick();
    chk("spurious_err", err, 1);
    chk("spurious_inflight", inflight, 0);
    c_out_valid = 0; c_out_ready = 0;

    // Reset after 3 of 6 words of a cfg=1 key load
    h_key_valid = 1; h_key_size_cfg = 1; h_key_inverse = 1; c_key_ready = 1;
    tick();
    tick(); tick(); tick();
    chk("midkey_busy", busy, 1);
    chk("midkey_cfg", c_key_size_cfg, 1);
    rst = 0;
    #1;
    chk("midkey_rst_key_ready", h_key_ready, 0);
    chk("midkey_rst_key_valid", c_key_valid, 0);
    chk("midkey_rst_busy", busy, 0);
    chk("midkey_rst_err", err, 0);
    chk("midkey_rst_cfg", c_key_size_cfg, 0);
    chk("midkey_rst_inv", c_key_inverse, 0);
    h_key_valid = 0; c_key_ready = 0;
    tick();
    rst = 1;
    tick();
    chk("midkey_release_idle", busy, 0);
    do_seed(80'h0BAD_F00D_0000_0000_0001);
    h_data_valid = 1; c_data_ready = 1;
    #1;
    chk("midkey_keyed_cleared", h_data_ready, 0);
    h_data_valid = 0; c_data_ready = 0;

    // Seed and key requested together: seed first, then cfg=3 key (4 words, err)
    h_seed_valid = 1; h_seed_data = 80'h5EED; c_seed_ready = 1;
    h_key_valid = 1; h_key_size_cfg = 3; h_key_inverse = 0; c_key_ready = 1;
    tick();
    chk("arb_seed_first", c_seed_valid, 1);
    chk("arb_seed_ready", h_seed_ready, 1);
    chk("arb_no_key", h_key_ready, 0);
    tick();
    h_seed_valid = 0; c_seed_ready = 0;
    chk("arb_seed_done", busy, 0);
    chk("arb_err_before", err, 0);
    tick();
    chk("arb_key_entered", h_key_ready, 1);
    chk("arb_cfg3_err", err, 1);
    run_key(4, 2'd0, 1'b0);
    chk("arb_err_sticky", err, 1);
    h_data_valid = 1; c_data_ready = 1;
    #1;
    chk("arb_data_open", h_data_ready, 1);
    h_data_valid = 0; c_data_ready = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
